// File: rtl/id_stage.sv
// id_stage: ARM ID stage - decode, condition check, 15-entry register file, ID/EX register.
// Revision 1.0 - initial release.
`default_nettype none

module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hazard,
  input  logic [31:0] pc_in,
  input  logic [31:0] instruction_in,
  input  logic [3:0]  sr,
  input  logic        wb_en,
  input  logic [3:0]  wb_dest,
  input  logic [31:0] wb_value,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic        two_src,
  output logic [31:0] pc_out,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic        mem_w_en_out,
  output logic        b_out,
  output logic        s_out,
  output logic [3:0]  exe_cmd_out,
  output logic [31:0] val_rn_out,
  output logic [31:0] val_rm_out,
  output logic        imm_out,
  output logic [11:0] shift_operand_out,
  output logic [23:0] signed_imm_24_out,
  output logic [3:0]  dest_out,
  output logic [3:0]  src1_out,
  output logic [3:0]  src2_out
);

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  logic [3:0]  w_cond, w_opcode;
  logic [1:0]  w_mode;
  logic        w_imm, w_s_bit, w_is_str, w_cond_ok, w_ctl_ok;
  logic        w_n, w_z, w_c, w_v;
  logic        w_wb, w_mr, w_mw, w_b, w_s;
  logic [3:0]  w_exe;
  logic [31:0] w_val_rn, w_val_rm;

  logic [31:0] rf_q [15];

  assign w_cond   = instruction_in[31:28];
  assign w_mode   = instruction_in[27:26];
  assign w_imm    = instruction_in[25];
  assign w_opcode = instruction_in[24:21];
  assign w_s_bit  = instruction_in[20];
  assign {w_n, w_z, w_c, w_v} = sr;

  assign w_is_str = (w_mode == MODE_MEM) && !w_s_bit;
  assign src1     = instruction_in[19:16];
  assign src2     = w_is_str ? instruction_in[15:12] : instruction_in[3:0];
  assign two_src  = !w_imm || w_is_str;

  always_comb begin
    w_cond_ok = 1'b0;
    case (w_cond)
      4'b0000: w_cond_ok = w_z;
      4'b0001: w_cond_ok = !w_z;
      4'b0010: w_cond_ok = w_c;
      4'b0011: w_cond_ok = !w_c;
      4'b0100: w_cond_ok = w_n;
      4'b0101: w_cond_ok = !w_n;
      4'b0110: w_cond_ok = w_v;
      4'b0111: w_cond_ok = !w_v;
      4'b1000: w_cond_ok = w_c && !w_z;
      4'b1001: w_cond_ok = !w_c || w_z;
      4'b1010: w_cond_ok = (w_n == w_v);
      4'b1011: w_cond_ok = (w_n != w_v);
      4'b1100: w_cond_ok = !w_z && (w_n == w_v);
      4'b1101: w_cond_ok = w_z || (w_n != w_v);
      4'b1110: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_wb  = 1'b0;
    w_mr  = 1'b0;
    w_mw  = 1'b0;
    w_b   = 1'b0;
    w_s   = 1'b0;
    w_exe = 4'b0000;
    case (w_mode)
      MODE_DP: begin
        w_wb = 1'b1;
        w_s  = w_s_bit;
        case (w_opcode)
          4'b1101: w_exe = 4'b0001;
          4'b1111: w_exe = 4'b1001;
          4'b0100: w_exe = 4'b0010;
          4'b0101: w_exe = 4'b0011;
          4'b0010: w_exe = 4'b0100;
          4'b0110: w_exe = 4'b0101;
          4'b0000: w_exe = 4'b0110;
          4'b1100: w_exe = 4'b0111;
          4'b0001: w_exe = 4'b1000;
          4'b1010: begin w_exe = 4'b0100; w_wb = 1'b0; end
          4'b1000: begin w_exe = 4'b0110; w_wb = 1'b0; end
          default: begin w_wb = 1'b0; w_s = 1'b0; end
        endcase
      end
      MODE_MEM: begin
        w_exe = 4'b0010;
        w_wb  = w_s_bit;
        w_mr  = w_s_bit;
        w_mw  = !w_s_bit;
      end
      MODE_BR: w_b = 1'b1;
      default: ;
    endcase
  end

  assign w_ctl_ok = w_cond_ok && !hazard;

  // Write-back in this cycle is bypassed so the ID/EX register captures the newest value.
  function automatic logic [31:0] rf_read(input logic [3:0] idx);
    if (idx == 4'd15)
      return 32'd0;
    else if (wb_en && (wb_dest == idx))
      return wb_value;
    else
      return rf_q[idx];
  endfunction

  assign w_val_rn = rf_read(src1);
  assign w_val_rm = rf_read(src2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 15; i++) rf_q[i] <= 32'(i);
    end else if (wb_en && (wb_dest != 4'd15)) begin
      rf_q[wb_dest] <= wb_value;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      pc_out            <= '0;
      wb_en_out         <= 1'b0;
      mem_r_en_out      <= 1'b0;
      mem_w_en_out      <= 1'b0;
      b_out             <= 1'b0;
      s_out             <= 1'b0;
      exe_cmd_out       <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      imm_out           <= 1'b0;
      shift_operand_out <= '0;
      signed_imm_24_out <= '0;
      dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
    end else begin
      pc_out            <= pc_in;
      wb_en_out         <= w_wb  && w_ctl_ok;
      mem_r_en_out      <= w_mr  && w_ctl_ok;
      mem_w_en_out      <= w_mw  && w_ctl_ok;
      b_out             <= w_b   && w_ctl_ok;
      s_out             <= w_s   && w_ctl_ok;
      exe_cmd_out       <= w_ctl_ok ? w_exe : 4'b0000;
      val_rn_out        <= w_val_rn;
      val_rm_out        <= w_val_rm;
      imm_out           <= w_imm;
      shift_operand_out <= instruction_in[11:0];
      signed_imm_24_out <= instruction_in[23:0];
      dest_out          <= instruction_in[15:12];
      src1_out          <= src1;
      src2_out          <= src2;
    end
  end

endmodule

`default_nettype wire
